// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants used by the receiver path
//                and its downstream byte FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Native data width of the UART receiver
    localparam int UART_WIDTH = 8;

    typedef logic [UART_WIDTH-1:0] uart_byte_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
//  Module      : uart_fifo_mem
//  Description : Register-array storage for the UART RX FIFO. One synchronous
//                write port, one asynchronous read port, contents not reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = UART_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    // Capture the incoming byte into the addressed entry
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head entry is read combinationally so the FIFO can fall through
    always_comb begin
        rdata = mem[raddr];
    end

endmodule : uart_fifo_mem

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through byte FIFO behind the UART receiver.
//                Tracks fill level in a dedicated counter and raises a sticky
//                overflow flag when a byte arrives into a full buffer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = UART_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_ok,
    input  logic                  pop,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clear_ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic                  do_pop;
    logic                  do_wr;
    logic                  drop;
    logic                  is_full;
    logic                  not_empty;
    logic [WIDTH-1:0]      head_data;

    // Status decode from the count register and next-state computation.
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    // the byte; a pop against an empty FIFO is ignored (no bypass).
    always_comb begin
        not_empty  = (count_q != '0);
        is_full    = (count_q == CNT_W'(DEPTH));
        do_pop     = pop & not_empty;
        do_wr      = rx_ok & (~is_full | do_pop);
        drop       = rx_ok & is_full & ~do_pop;

        wptr_d     = do_wr  ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = do_pop ? rptr_q + 1'b1 : rptr_q;
        count_d    = count_q + CNT_W'(do_wr) - CNT_W'(do_pop);

        // A dropped byte in the same cycle as a clear keeps the flag set
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Pointer, count and flag state; reset discards all contents at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wptr_q),
        .wdata (rx_data),
        .raddr (rptr_q),
        .rdata (head_data)
    );

    // Drive outputs; stale memory contents are hidden while empty
    always_comb begin
        out_valid = not_empty;
        full      = is_full;
        count     = count_q;
        overflow  = overflow_q;
        out_data  = not_empty ? head_data : '0;
    end

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo (4-entry configuration)
//                using a byte scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 2;
    localparam int WIDTH      = 8;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk;
    logic                reset;
    logic [WIDTH-1:0]    rx_data;
    logic                rx_ok;
    logic                pop;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                overflow;
    logic                clear_ovf;

    logic [7:0] exp_q [$];
    logic       m_ovf;
    int         n_checks;
    int         n_errors;

    uart_rx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_ok     (rx_ok),
        .pop       (pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare every visible output against the scoreboard model
    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check_eq({tag, ".count"},     32'(count),     32'(exp_q.size()));
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        check_eq({tag, ".full"},      32'(full),      32'(exp_q.size() == DEPTH));
        check_eq({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check_eq({tag, ".out_data"},  32'(out_data),  32'(head));
    endtask

    // One clock of stimulus: drive on negedge, release just after posedge.
    // Popped bytes are compared to the scoreboard head before the edge.
    task automatic step(input logic ok, input logic [7:0] d, input logic p, input logic clr);
        logic do_pop;
        logic do_wr;
        logic [7:0] exp_b;
        @(negedge clk);
        do_pop = p && (exp_q.size() != 0);
        do_wr  = ok && ((exp_q.size() < DEPTH) || do_pop);
        if (do_pop) begin
            exp_b = exp_q.pop_front();
            check_eq("pop_data", 32'(out_data), 32'(exp_b));
        end
        if (do_wr) exp_q.push_back(d);
        if (ok && !do_wr)  m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        rx_ok     = ok;
        rx_data   = d;
        pop       = p;
        clear_ovf = clr;
        @(posedge clk);
        #1;
        rx_ok     = 1'b0;
        pop       = 1'b0;
        clear_ovf = 1'b0;
        rx_data   = 8'h00;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_ovf     = 1'b0;
        rx_ok     = 1'b0;
        rx_data   = 8'h00;
        pop       = 1'b0;
        clear_ovf = 1'b0;
        reset     = 1'b1;

        // Reset held four cycles
        repeat (4) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Two bytes, pulses three cycles apart, then drain and over-pop
        step(1'b1, 8'hCD, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h87, 1'b0, 1'b0);
        check_state("two_push");
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("pop1");
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("pop2");
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("pop_empty");

        // Fill to full, then one more byte overflows
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check_state("filled");
        step(1'b1, 8'h05, 1'b0, 1'b0);
        check_state("overflow");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("drained");

        // Clear the flag, then push and pop together while full
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_state("clear_ovf");
        for (int i = 0; i < 4; i++) step(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check_state("full_push_pop");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("drained2");

        // Push and pop on an empty FIFO: pop ignored, byte stored
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        check_state("empty_push_pop");
        // Push and pop when partially filled: level unchanged
        step(1'b1, 8'h3D, 1'b1, 1'b0);
        check_state("mid_push_pop");
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap with one-in-one-out traffic
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_state("wrap");

        // Asynchronous reset between edges with three bytes held
        for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h73, 1'b0, 1'b0);
        step(1'b1, 8'h74, 1'b0, 1'b0);
        check_state("pre_reset_ovf");
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        m_ovf = 1'b0;
        check_state("async_reset");
        @(negedge clk);
        reset = 1'b0;

        // First byte after reset lands at the head
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check_state("post_reset");

        // Overflow, set-wins against clear, then a plain clear
        for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h63, 1'b0, 1'b0);
        check_state("ovf_again");
        step(1'b1, 8'h64, 1'b0, 1'b1);
        check_state("set_wins");
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_state("cleared");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo

`default_nettype wire
